// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded from address bits [3:2]
//   - STATUS register bit positions
//   - bus and transmit state encodings
//   - divisor helper (a stored divisor of 0 behaves as 1)
package uart_tx_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic {
        BIDLE,
        BACK
    } bus_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [15:0] eff_divisor(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side bus for the UART transmitter window.
//   i_request : access request, held high until o_ready is seen
//   i_rw      : 1 = write, 0 = read
//   i_address : window offset, bits [3:2] select the register
//   i_wdata   : write data
//   o_rdata   : read data, valid while o_ready is high
//   o_ready   : access complete
// master = CPU / decoder side, slave = UART.
interface uart_tx_if;
    logic        i_request;
    logic        i_rw;
    logic [31:0] i_address;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;

    modport master (
        output i_request, i_rw, i_address, i_wdata,
        input  o_rdata, o_ready
    );

    modport slave (
        input  i_request, i_rw, i_address, i_wdata,
        output o_rdata, o_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_push, i_wdata  : write a byte (ignored when full)
//   i_pop            : discard the head byte (ignored when empty)
//   o_rdata          : head byte, valid whenever o_empty is low
//   o_full, o_empty  : occupancy flags
//   o_count          : number of stored bytes
// Pointers are log2(DEPTH) bits and wrap naturally; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic [7:0]             i_wdata,
    input  logic                   i_pop,
    output logic [7:0]             o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    // Storage has no reset so it can map onto plain distributed/block memory.
    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
//   i_clock : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : CPU bus (slave side), registers DATA/STATUS/DIVISOR/reserved
//   UART_TX : registered serial output, idle high
// A write to DATA while the FIFO is full is held off (o_ready stays low) and
// retried every cycle until the transmitter pops a byte.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int DEFAULT_DIVISOR = 434
) (
    input  logic    i_clock,
    input  logic    i_reset,
    uart_tx_if.slave bus,
    output logic    UART_TX
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bus_state_e  bus_state_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        ready_q;
    logic [15:0] div_q;

    tx_state_e   tx_state_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] baud_q;
    logic [15:0] bit_div_q;
    logic        tx_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [15:0]   count_ext;

    logic [1:0]  reg_sel;
    logic        access_ok;
    logic        busy;
    logic [31:0] status_word;
    logic        unused_bits;

    assign reg_sel   = bus.i_address[3:2];
    assign busy      = (tx_state_q != TX_IDLE);
    assign count_ext = 16'(fifo_count);

    // Full is the pre-pop value, so a push that coincides with a pop on a
    // full FIFO is still held off for this cycle.
    assign access_ok = (bus_state_q == BIDLE) && bus.i_request &&
                       !(bus.i_rw && (reg_sel == REG_DATA) && fifo_full);
    assign fifo_push = access_ok && bus.i_rw && (reg_sel == REG_DATA);
    assign fifo_pop  = (tx_state_q == TX_IDLE) && !fifo_empty;

    always_comb begin
        status_word = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = busy;
        status_word[STAT_COUNT_LSB +: 8] = count_ext[7:0];
    end

    always_comb begin
        rdata_d = '0;
        if (!bus.i_rw) begin
            case (reg_sel)
                REG_STATUS:  rdata_d = status_word;
                REG_DIVISOR: rdata_d = {16'h0000, div_q};
                default:     rdata_d = '0;
            endcase
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (fifo_push),
        .i_wdata (bus.i_wdata[7:0]),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Bus FSM: one access per request; BACK waits for the request to drop.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bus_state_q <= BIDLE;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            div_q       <= 16'(DEFAULT_DIVISOR);
        end else begin
            case (bus_state_q)
                BIDLE: begin
                    if (access_ok) begin
                        rdata_q     <= rdata_d;
                        ready_q     <= 1'b1;
                        bus_state_q <= BACK;
                        if (bus.i_rw && (reg_sel == REG_DIVISOR)) begin
                            div_q <= bus.i_wdata[15:0];
                        end
                    end
                end
                BACK: begin
                    if (!bus.i_request) begin
                        ready_q     <= 1'b0;
                        rdata_q     <= '0;
                        bus_state_q <= BIDLE;
                    end
                end
            endcase
        end
    end

    // TX FSM. The divisor is captured at frame start so register writes
    // never disturb a frame in flight. tx_q changes on the same edge as the
    // state, keeping the line glitch-free.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            baud_q     <= '0;
            bit_div_q  <= 16'd1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q    <= fifo_rdata;
                        bit_div_q  <= eff_divisor(div_q);
                        baud_q     <= eff_divisor(div_q) - 16'd1;
                        tx_q       <= 1'b0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_q == 16'd0) begin
                        baud_q     <= bit_div_q - 16'd1;
                        bit_cnt_q  <= '0;
                        tx_q       <= shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (baud_q == 16'd0) begin
                        baud_q <= bit_div_q - 16'd1;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (baud_q == 16'd0) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_rdata = rdata_q;
    assign UART_TX     = tx_q;

    // Address/data bits outside the decoded fields are intentionally ignored.
    assign unused_bits = ^{bus.i_address[31:4], bus.i_address[1:0],
                           bus.i_wdata[31:16], count_ext[15:8]};

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps with random data, a queue of
// expected frames (byte + bit period) and a line monitor that checks every
// serial sample against the 8N1 frame shape.
module tb_uart_tx;
    import uart_tx_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         b2b;
    } frame_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   uart_line;
    int     total = 0;
    int     bad = 0;
    frame_t exp_q[$];
    bit     mon_busy = 1'b0;

    always #5 clk = ~clk;

    uart_tx_if bus ();

    uart_tx #(
        .FIFO_DEPTH      (16),
        .DEFAULT_DIVISOR (434)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus),
        .UART_TX (uart_line)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Line monitor: a frame is 10 bit periods of div samples each:
    // start 0, data LSB first, stop 1. Reset abandons the current frame.
    initial begin : serial_monitor
        frame_t cur;
        int     idx;
        int     gap;
        int     bit_no;
        logic   exp_bit;
        idx = 0;
        gap = 0;
        cur = '{8'h00, 1, 1'b0};
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy = 1'b0;
                gap = 0;
            end else if (!mon_busy) begin
                if (uart_line === 1'b1) begin
                    gap++;
                end else if (exp_q.size() == 0) begin
                    check("spurious_start", 32'(uart_line), 32'd1);
                end else begin
                    cur = exp_q.pop_front();
                    if (cur.b2b) check("frame_gap", 32'(gap), 32'd1);
                    mon_busy = 1'b1;
                    idx = 0;
                end
            end
            if (!rst && mon_busy) begin
                bit_no = idx / cur.div;
                if (bit_no == 0)      exp_bit = 1'b0;
                else if (bit_no == 9) exp_bit = 1'b1;
                else                  exp_bit = cur.data[bit_no-1];
                check($sformatf("serial_%02h_bit%0d", cur.data, bit_no), 32'(uart_line), 32'(exp_bit));
                idx++;
                if (idx == 10 * cur.div) begin
                    mon_busy = 1'b0;
                    gap = 0;
                end
            end
        end
    end

    task automatic bus_xfer(input logic rw, input logic [1:0] sel, input logic [31:0] wdata,
                            input int hold, output logic [31:0] rdata, output int lat);
        logic [31:0] rnd;
        rnd = $urandom();
        bus.i_rw      = rw;
        bus.i_address = {rnd[31:4], sel, rnd[1:0]};
        bus.i_wdata   = wdata;
        bus.i_request = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.o_ready !== 1'b1 && lat < 2000);
        rdata = bus.o_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("ready_held", 32'(bus.o_ready), 32'd1);
        end
        bus.i_request = 1'b0;
        @(negedge clk);
        check("ready_release", 32'(bus.o_ready), 32'd0);
        check("rdata_release", bus.o_rdata, 32'd0);
    endtask

    task automatic read_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        bus_xfer(1'b0, sel, $urandom(), 0, rd, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check(tag, rd, exp);
    endtask

    task automatic write_div(input logic [15:0] d);
        logic [31:0] rnd;
        logic [31:0] rd;
        int          lat;
        rnd = $urandom();
        bus_xfer(1'b1, REG_DIVISOR, {rnd[31:16], d}, 0, rd, lat);
        check("div_write_lat", 32'(lat), 32'd1);
    endtask

    task automatic push_byte(input logic [7:0] b, input int div, input bit b2b,
                             input int hold, output int lat);
        logic [31:0] rnd;
        logic [31:0] rd;
        rnd = $urandom();
        exp_q.push_back('{b, div, b2b});
        bus_xfer(1'b1, REG_DATA, {rnd[31:8], b}, hold, rd, lat);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_line_idle", 32'(mon_busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        bus.i_request = 1'b0;
        bus.i_rw      = 1'b0;
        bus.i_address = '0;
        bus.i_wdata   = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(bus.o_ready), 32'd0);
        check("reset_rdata", bus.o_rdata, 32'd0);
        check("reset_tx", 32'(uart_line), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Reset state through the register map
        read_reg("t1_status", REG_STATUS, 32'h0000_0002);
        check("t1_tx_idle", 32'(uart_line), 32'd1);
        read_reg("t1_divisor", REG_DIVISOR, 32'd434);
        read_reg("t1_reserved", REG_RSVD, 32'd0);
        read_reg("t1_data_read", REG_DATA, 32'd0);

        // Divisor 4, frame of 0x55, busy during and after
        write_div(16'd4);
        read_reg("t2_divisor", REG_DIVISOR, 32'd4);
        push_byte(8'h55, 4, 1'b0, 0, lat);
        check("t2_push_lat", 32'(lat), 32'd1);
        repeat (8) @(negedge clk);
        read_reg("t2_status_busy", REG_STATUS, 32'h0000_0006);
        wait_drain(200);
        read_reg("t2_status_idle", REG_STATUS, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            push_byte(8'($urandom()), 4, 1'b0, int'($urandom_range(0, 3)), lat);
            check("rand_push_lat", 32'(lat), 32'd1);
            wait_drain(200);
        end

        // Long-held request pushes exactly once
        write_div(16'd16);
        push_byte(8'($urandom()), 16, 1'b0, 0, lat);
        push_byte(8'hA5, 16, 1'b1, 20, lat);
        check("t3_push_lat", 32'(lat), 32'd1);
        read_reg("t3_status_one_push", REG_STATUS, 32'h0000_0104);
        wait_drain(1000);

        // Fill FIFO: one byte in the shifter + 16 queued, then a blocked write
        for (int i = 0; i < 17; i++) begin
            push_byte(8'($urandom()), 16, (i != 0), 0, lat);
            check("t4_push_lat", 32'(lat), 32'd1);
        end
        read_reg("t4_status_full", REG_STATUS, 32'h0000_1005);
        push_byte(8'($urandom()), 16, 1'b1, 0, lat);
        check("t4_blocked_until_pop", 32'(lat > 20), 32'd1);
        check("t4_blocked_completes", 32'(lat < 2000), 32'd1);
        wait_drain(18 * 170 + 200);

        // Divisor 0 behaves as 1; mid-frame divisor change
        write_div(16'd0);
        read_reg("t5_div_zero", REG_DIVISOR, 32'd0);
        push_byte(8'($urandom()), 1, 1'b0, 0, lat);
        wait_drain(100);
        write_div(16'd3);
        push_byte(8'($urandom()), 3, 1'b0, 0, lat);
        push_byte(8'($urandom()), 8, 1'b1, 0, lat);
        check("t5_in_frame", 32'(mon_busy), 32'd1);
        write_div(16'd8);
        read_reg("t5_div_eight", REG_DIVISOR, 32'd8);
        wait_drain(300);

        // Reset in the middle of the data bits
        push_byte(8'($urandom()), 8, 1'b0, 0, lat);
        repeat (30) @(negedge clk);
        check("t6_in_frame", 32'(mon_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_tx_after_reset", 32'(uart_line), 32'd1);
        check("t6_ready_after_reset", 32'(bus.o_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_reg("t6_status", REG_STATUS, 32'h0000_0002);
        read_reg("t6_divisor", REG_DIVISOR, 32'd434);
        push_byte(8'($urandom()), 434, 1'b0, 0, lat);
        check("t6_push_lat", 32'(lat), 32'd1);
        wait_drain(5000);

        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
